// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - debounced front-panel editor for BCD time and alarm digits
// Optional feature macro: AUTO_REPEAT_EN (hold-to-repeat on key_inc).
module time_set_ctrl #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
    parameter logic [23:0] HOLD_CYCLES     = 24'd10000000,
    parameter logic [23:0] REPEAT_CYCLES   = 24'd2500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_sel,
    input  logic       key_inc,
    input  logic       key_alarm,
    output logic [3:0] set_sec_ge,
    output logic [3:0] set_sec_shi,
    output logic [3:0] set_min_ge,
    output logic [3:0] set_min_shi,
    output logic [3:0] set_hour_ge,
    output logic [3:0] set_hour_shi,
    output logic       set_time_finish,
    output logic [3:0] clock_min_ge,
    output logic [3:0] clock_min_shi,
    output logic [3:0] clock_hour_ge,
    output logic [3:0] clock_hour_shi,
    output logic       clock_en,
    output logic       edit_active,
    output logic [2:0] edit_digit
);

    typedef enum logic [1:0] {IDLE, SET_TIME, SET_ALARM} state_t;

    state_t      state;
    logic [3:0]  raw, sync1, sync2, level, level_d, press;
    logic [19:0] db_cnt [4];
    logic        mode_ev, sel_ev, inc_ev, alarm_ev, rep_ev;

    // Key bit order: 0 mode, 1 sel, 2 inc, 3 alarm
    assign raw   = {key_alarm, key_inc, key_sel, key_mode};
    assign press = level & ~level_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DEBOUNCE_CYCLES - 20'd1) begin
                    db_cnt[i] <= '0;
                    level[i]  <= ~level[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 20'd1;
                end
            end
        end
    end

    assign mode_ev  = press[0];
    assign sel_ev   = press[1] & ~press[0];
    assign inc_ev   = (press[2] | rep_ev) & ~press[0] & ~press[1];
    assign alarm_ev = press[3];

`ifdef AUTO_REPEAT_EN
    logic [23:0] hold_cnt;
    logic        hold_run, repeating;

    // hold_cnt equals the number of cycles since the press (or the last repeat)
    assign rep_ev = hold_run && level[2] &&
                    (repeating ? (hold_cnt == REPEAT_CYCLES) : (hold_cnt == HOLD_CYCLES));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            hold_run  <= 1'b0;
            repeating <= 1'b0;
        end else if (!level[2] || mode_ev || sel_ev || state == IDLE) begin
            hold_cnt  <= '0;
            hold_run  <= 1'b0;
            repeating <= 1'b0;
        end else if (press[2]) begin
            hold_cnt  <= 24'd1;
            hold_run  <= 1'b1;
            repeating <= 1'b0;
        end else if (hold_run) begin
            if (rep_ev) begin
                hold_cnt  <= 24'd1;
                repeating <= 1'b1;
            end else begin
                hold_cnt <= hold_cnt + 24'd1;
            end
        end
    end
`else
    logic unused_params;
    assign unused_params = ^{HOLD_CYCLES, REPEAT_CYCLES};
    assign rep_ev        = 1'b0;
`endif

    function automatic logic [3:0] bump(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? 4'd0 : v + 4'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            set_sec_ge      <= '0;
            set_sec_shi     <= '0;
            set_min_ge      <= '0;
            set_min_shi     <= '0;
            set_hour_ge     <= '0;
            set_hour_shi    <= '0;
            set_time_finish <= 1'b0;
            clock_min_ge    <= '0;
            clock_min_shi   <= '0;
            clock_hour_ge   <= '0;
            clock_hour_shi  <= '0;
            clock_en        <= 1'b0;
            edit_active     <= 1'b0;
            edit_digit      <= '0;
        end else begin
            set_time_finish <= 1'b0;
            if (alarm_ev) clock_en <= ~clock_en;
            case (state)
                IDLE: begin
                    if (mode_ev) begin
                        state       <= SET_TIME;
                        edit_active <= 1'b1;
                        edit_digit  <= '0;
                    end
                end
                SET_TIME: begin
                    if (mode_ev) begin
                        state           <= SET_ALARM;
                        edit_digit      <= '0;
                        set_time_finish <= 1'b1;
                    end else if (sel_ev) begin
                        edit_digit <= (edit_digit >= 3'd5) ? 3'd0 : edit_digit + 3'd1;
                    end else if (inc_ev) begin
                        case (edit_digit)
                            3'd0: set_sec_ge  <= bump(set_sec_ge, 4'd9);
                            3'd1: set_sec_shi <= bump(set_sec_shi, 4'd5);
                            3'd2: set_min_ge  <= bump(set_min_ge, 4'd9);
                            3'd3: set_min_shi <= bump(set_min_shi, 4'd5);
                            3'd4: set_hour_ge <= bump(set_hour_ge, (set_hour_shi < 4'd2) ? 4'd9 : 4'd3);
                            3'd5: begin
                                set_hour_shi <= bump(set_hour_shi, 4'd2);
                                // Entering the 20s hours: keep the hour at 23 or below
                                if (set_hour_shi == 4'd1 && set_hour_ge > 4'd3) set_hour_ge <= 4'd3;
                            end
                            default: ;
                        endcase
                    end
                end
                SET_ALARM: begin
                    if (mode_ev) begin
                        state       <= IDLE;
                        edit_active <= 1'b0;
                        edit_digit  <= '0;
                    end else if (sel_ev) begin
                        edit_digit <= (edit_digit >= 3'd3) ? 3'd0 : edit_digit + 3'd1;
                    end else if (inc_ev) begin
                        case (edit_digit)
                            3'd0: clock_min_ge  <= bump(clock_min_ge, 4'd9);
                            3'd1: clock_min_shi <= bump(clock_min_shi, 4'd5);
                            3'd2: clock_hour_ge <= bump(clock_hour_ge, (clock_hour_shi < 4'd2) ? 4'd9 : 4'd3);
                            3'd3: begin
                                clock_hour_shi <= bump(clock_hour_shi, 4'd2);
                                if (clock_hour_shi == 4'd1 && clock_hour_ge > 4'd3) clock_hour_ge <= 4'd3;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
